nios2_oci_dct_trace_capture: RTL and testbench
==============================================

Name: nios2_oci_dct_trace_capture

Overview:
- Parametrised successor to the processor OCI test-bench debug-capture-trace (DCT) sink.
- The sink only received the trace bus. This block captures packed DCT words and their slot counts into a first-word-fall-through (FWFT) FIFO, counts dropped entries, and exposes the trace through a ready/valid read port.
- Sequences end-of-test drain from test_ending / test_has_ended.
- Sits beside the Nios II OCI in simulation and debug builds.

Parameters:
- SLOT_W, 3: bits per trace slot.
- SLOTS, 10: slots per DCT word. BUF_W = SLOT_W*SLOTS (30 by default).
- CNT_W, 4: width of dct_count. Must be ≥ clog2(SLOTS+1).
- DEPTH, 16: FIFO entries. Power of two, ≥2.
- OVF_W, 16: overflow counter width.

Ports:
- clk  in  1  block clock.
- reset  in  1  synchronous, active-high reset.
- dct_buffer  in  BUF_W  packed trace slots; slot 0 is in the LSBs.
- dct_count  in  CNT_W  number of valid slots in dct_buffer.
- dct_valid  in  1  dct_buffer/dct_count qualify this cycle.
- test_ending  in  1  test is finishing; stop capture.
- test_has_ended  in  1  test fully ended.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  FIFO non-empty.
- rd_buffer  out  BUF_W  head entry data.
- rd_count  out  CNT_W  head entry slot count.
- fill_level  out  clog2(DEPTH+1)  current occupancy.
- overflow_count  out  OVF_W  dropped entries, saturating.
- state  out  2  FSM state.
- drain_done  out  1  DONE state reached.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, FIFO empty, all outputs 0. Reset in any state, including mid-drain, discards all contents immediately.
- FSM encoding: IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
- IDLE → CAPTURE on dct_valid=1. The qualifying entry in that same cycle is captured.
- CAPTURE → DRAIN on test_ending=1 or test_has_ended=1. A push in that same cycle is still accepted.
- DRAIN → DONE when FIFO is empty (after any pop this cycle) and test_has_ended=1. test_has_ended may already have been high earlier.
- DONE is sticky until reset; drain_done=1 only in DONE.
- Push qualification: dct_valid=1, dct_count≠0, state is IDLE or CAPTURE.
  - dct_count=0: entry silently discarded.
  - dct_count>SLOTS: stored count clamped to SLOTS; buffer stored unchanged.
- Full FIFO:
  - Push without simultaneous pop: entry dropped; overflow_count +1, saturating at all-ones.
  - Push with simultaneous pop: both succeed; fill_level unchanged.
- dct_valid in DRAIN or DONE: ignored; overflow_count does not change.
- Read port (FWFT):
  - rd_valid = (fill_level≠0).
  - Pop when rd_valid && rd_ready. rd_ready while empty has no effect.
  - rd_buffer/rd_count present the head entry; both are 0 when empty.
  - Latency: entry pushed at clock edge N is visible on the read port after edge N.
  - Data must not be lost or reordered through pointer wrap.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer MSB.
- fill_level and state are registered, updated on the same edge as push/pop.

Optional Feature:
- Macro: DCT_TRACE_SLOT_TOTAL_EN.
- Defined:
  - Adds output slot_total, 32 bits, reset 0.
  - Adds the stored (clamped) count of every accepted push; wraps modulo 2^32.
  - Dropped and discarded entries do not contribute.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package nios2_oci_dct_pkg:
  - FSM state localparams/encoding.
  - Default SLOT_W/SLOTS/CNT_W.
  - clog2-based width helper.
- Sub-module nios2_oci_dct_fifo:
  - Parametrised synchronous FWFT FIFO (data width BUF_W+CNT_W, DEPTH).
  - Exposes push/pop/full/empty/level.
- Top level holds the FSM, qualification/clamp logic, overflow counter and optional slot_total.

Test Plan:
- Reset, then 3 pushes (counts 10, 4, 1), rd_ready=1 throughout → same 3 entries out in order, 1-cycle latency; fill_level returns to 0; state=CAPTURE.
- rd_ready=0, 18 valid pushes with DEPTH=16 → fill_level=16, overflow_count=2; first 16 entries read back intact.
- Full FIFO, push and pop in the same cycle → fill_level stays 16, overflow_count unchanged, pushed entry is last out.
- Push with dct_count=0 → not stored. Push with dct_count=15 → rd_count=10.
- test_ending with 5 queued entries, then pushes during DRAIN → pushes ignored, overflow_count unchanged. After 5 pops with test_has_ended=1 → state=DONE, drain_done=1.
- Assert reset during DRAIN with 7 entries queued → next cycle: empty, state=IDLE, overflow_count=0. With DCT_TRACE_SLOT_TOTAL_EN, pushes of counts 3 and 12 → slot_total=13.

Source files
------------

// File: rtl/nios2_oci_dct_pkg.sv
// Shared definitions for the Nios II OCI DCT trace-capture block.
//   - FSM state encoding (IDLE=0, CAPTURE=1, DRAIN=2, DONE=3)
//   - default trace geometry (slot width, slots per word, count width)
//   - occupancy-width helper used by the FIFO and the top level
package nios2_oci_dct_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } dct_state_e;

    localparam int DCT_SLOT_W_DEF = 3;
    localparam int DCT_SLOTS_DEF  = 10;
    localparam int DCT_CNT_W_DEF  = 4;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int dct_level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// Synchronous first-word-fall-through FIFO for captured DCT words.
// Ports:
//   clk, reset      block clock, synchronous active-high reset
//   push, wr_data   write request and data
//   pop             read request; the head entry advances
//   rd_data         head entry, forced to 0 while empty
//   full, empty     occupancy flags
//   level           current number of stored entries
// A push into a full FIFO succeeds only if a pop happens in the same cycle.
module nios2_oci_dct_fifo
    import nios2_oci_dct_pkg::*;
#(
    parameter int DATA_W = 34,
    parameter int DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic                            pop,
    input  logic [DATA_W-1:0]               wr_data,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            full,
    output logic                            empty,
    output logic [dct_level_w(DEPTH)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = dct_level_w(DEPTH);

    // Pointers carry one extra MSB so that full and empty differ.
    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                do_push;
    logic                do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; the read side is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/nios2_oci_dct_trace_capture.sv
// DCT trace capture: buffers packed trace words with their slot counts in an
// FWFT FIFO, counts dropped entries and sequences the end-of-test drain.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   dct_buffer/dct_count/dct_valid  incoming trace word, slot count, qualifier
//   test_ending, test_has_ended   end-of-test indications
//   rd_ready / rd_valid           read handshake (pop on both high)
//   rd_buffer, rd_count           head entry (0 when empty)
//   fill_level                    FIFO occupancy
//   overflow_count                saturating count of dropped entries
//   state, drain_done             FSM state and DONE indication
//   slot_total                    running sum of accepted slot counts,
//                                 present only with DCT_TRACE_SLOT_TOTAL_EN
module nios2_oci_dct_trace_capture
    import nios2_oci_dct_pkg::*;
#(
    parameter int SLOT_W = DCT_SLOT_W_DEF,
    parameter int SLOTS  = DCT_SLOTS_DEF,
    parameter int CNT_W  = DCT_CNT_W_DEF,
    parameter int DEPTH  = 16,
    parameter int OVF_W  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SLOT_W*SLOTS-1:0]        dct_buffer,
    input  logic [CNT_W-1:0]               dct_count,
    input  logic                           dct_valid,
    input  logic                           test_ending,
    input  logic                           test_has_ended,
    input  logic                           rd_ready,
    output logic                           rd_valid,
    output logic [SLOT_W*SLOTS-1:0]        rd_buffer,
    output logic [CNT_W-1:0]               rd_count,
    output logic [dct_level_w(DEPTH)-1:0]  fill_level,
    output logic [OVF_W-1:0]               overflow_count,
    output logic [1:0]                     state,
    output logic                           drain_done
`ifdef DCT_TRACE_SLOT_TOTAL_EN
    ,
    output logic [31:0]                    slot_total
`endif
);

    localparam int BUF_W = SLOT_W * SLOTS;
    localparam int LVL_W = dct_level_w(DEPTH);

    dct_state_e              cur_state;
    dct_state_e              nxt_state;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    qual;
    logic                    accept;
    logic                    drop;
    logic                    drained;
    logic [CNT_W-1:0]        clamped_count;
    logic [BUF_W+CNT_W-1:0]  fifo_rd_data;

    assign rd_valid = !fifo_empty;          // same as fill_level != 0
    assign pop      = rd_valid && rd_ready;

    // Capture only before the drain starts; zero-slot words carry nothing.
    assign qual = dct_valid && (dct_count != '0) &&
                  ((cur_state == ST_IDLE) || (cur_state == ST_CAPTURE));
    assign clamped_count = (dct_count > CNT_W'(SLOTS)) ? CNT_W'(SLOTS) : dct_count;

    // A same-cycle pop frees the slot, so a push into a full FIFO survives.
    assign accept = qual && (!fifo_full || pop);
    assign drop   = qual && fifo_full && !pop;

    // No pushes happen in DRAIN, so occupancy after this edge is level - pop.
    assign drained = (fill_level == '0) || ((fill_level == LVL_W'(1)) && pop);

    nios2_oci_dct_fifo #(
        .DATA_W (BUF_W + CNT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (qual),
        .pop     (pop),
        .wr_data ({clamped_count, dct_buffer}),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fill_level)
    );

    assign {rd_count, rd_buffer} = fifo_rd_data;

    always_ff @(posedge clk) begin
        if (reset) cur_state <= ST_IDLE;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE:    if (dct_valid) nxt_state = ST_CAPTURE;
            ST_CAPTURE: if (test_ending || test_has_ended) nxt_state = ST_DRAIN;
            ST_DRAIN:   if (drained && test_has_ended) nxt_state = ST_DONE;
            ST_DONE:    nxt_state = ST_DONE;
            default:    nxt_state = ST_IDLE;
        endcase
    end

    assign state      = cur_state;
    assign drain_done = (cur_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset)
            overflow_count <= '0;
        else if (drop && (overflow_count != '1))
            overflow_count <= overflow_count + 1'b1;
    end

`ifdef DCT_TRACE_SLOT_TOTAL_EN
    always_ff @(posedge clk) begin
        if (reset)
            slot_total <= '0;
        else if (accept)
            slot_total <= slot_total + 32'(clamped_count);
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_nios2_oci_dct_trace_capture.sv
// Directed bench for nios2_oci_dct_trace_capture (default parameters).
// Build with DCT_TRACE_SLOT_TOTAL_EN defined to also exercise slot_total.
module tb_nios2_oci_dct_trace_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        test_ending;
    logic        test_has_ended;
    logic        rd_ready;
    logic        rd_valid;
    logic [29:0] rd_buffer;
    logic [3:0]  rd_count;
    logic [4:0]  fill_level;
    logic [15:0] overflow_count;
    logic [1:0]  state;
    logic        drain_done;
`ifdef DCT_TRACE_SLOT_TOTAL_EN
    logic [31:0] slot_total;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nios2_oci_dct_trace_capture dut (
        .clk            (clk),
        .reset          (reset),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_buffer      (rd_buffer),
        .rd_count       (rd_count),
        .fill_level     (fill_level),
        .overflow_count (overflow_count),
        .state          (state),
        .drain_done     (drain_done)
`ifdef DCT_TRACE_SLOT_TOTAL_EN
        ,
        .slot_total     (slot_total)
`endif
    );

    typedef struct packed {
        logic        vld;
        logic [29:0] dat;
        logic [3:0]  cnt;
        logic [4:0]  fill;
        logic [15:0] ovf;
        logic [1:0]  st;
        logic        done;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        v;
        logic [3:0]  c;
        logic [29:0] b;
        logic        te;
        logic        th;
        logic        rr;
        string       name;
        exp_t        e;
    } vec_t;

    function automatic exp_t ex(input logic vld, input logic [29:0] dat,
                                input logic [3:0] cnt, input logic [4:0] fill,
                                input logic [15:0] ovf, input logic [1:0] st,
                                input logic done);
        exp_t r;
        r.vld = vld; r.dat = dat; r.cnt = cnt; r.fill = fill;
        r.ovf = ovf; r.st = st; r.done = done;
        return r;
    endfunction

    function automatic vec_t mkv(input logic rst, input logic v, input logic [3:0] c,
                                 input logic [29:0] b, input logic te, input logic th,
                                 input logic rr, input string name, input exp_t e);
        vec_t r;
        r.rst = rst; r.v = v; r.c = c; r.b = b; r.te = te; r.th = th;
        r.rr = rr; r.name = name; r.e = e;
        return r;
    endfunction

    function automatic logic [29:0] pat(input int i);
        return 30'(i * 32'h0135_7913 + 32'h0BAD_F00D);
    endfunction

    function automatic logic [3:0] pcnt(input int i);
        return 4'((i % 10) + 1);
    endfunction

    // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic rst, input logic v, input logic [3:0] c,
                         input logic [29:0] b, input logic te, input logic th,
                         input logic rr);
        reset = rst; dct_valid = v; dct_count = c; dct_buffer = b;
        test_ending = te; test_has_ended = th; rd_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = {rd_valid, rd_buffer, rd_count, fill_level, overflow_count, state, drain_done};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got vld=%0b dat=%h cnt=%0d fill=%0d ovf=%0d st=%0d done=%0b; want vld=%0b dat=%h cnt=%0d fill=%0d ovf=%0d st=%0d done=%0b",
                     name, a.vld, a.dat, a.cnt, a.fill, a.ovf, a.st, a.done,
                     e.vld, e.dat, e.cnt, e.fill, e.ovf, e.st, e.done);
        end
    endtask

    localparam logic [29:0] A = 30'h1234_5678;
    localparam logic [29:0] B = 30'h0ABC_DEF1;
    localparam logic [29:0] C = 30'h3FFF_FFFF;
    localparam logic [29:0] D = 30'h1555_5555;
    localparam logic [29:0] E = 30'h2AAA_AAAA;

    vec_t tbl [9];

    initial begin
        reset = 1'b1; dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
        test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;

        //               rst v  cnt    buf te th rr  name            expected after the edge
        tbl[0] = mkv(1, 0, 4'd0,  0, 0, 0, 0, "reset",        ex(0, 0, 0,  0, 0, 0, 0));
        tbl[1] = mkv(0, 1, 4'd10, A, 0, 0, 1, "push_a",       ex(1, A, 10, 1, 0, 1, 0));
        tbl[2] = mkv(0, 1, 4'd4,  B, 0, 0, 1, "pop_a_push_b", ex(1, B, 4,  1, 0, 1, 0));
        tbl[3] = mkv(0, 1, 4'd1,  C, 0, 0, 1, "pop_b_push_c", ex(1, C, 1,  1, 0, 1, 0));
        tbl[4] = mkv(0, 0, 4'd0,  0, 0, 0, 1, "pop_c",        ex(0, 0, 0,  0, 0, 1, 0));
        tbl[5] = mkv(0, 1, 4'd0,  D, 0, 0, 0, "count_zero",   ex(0, 0, 0,  0, 0, 1, 0));
        tbl[6] = mkv(0, 1, 4'd15, E, 0, 0, 0, "count_clamp",  ex(1, E, 10, 1, 0, 1, 0));
        tbl[7] = mkv(0, 0, 4'd0,  0, 0, 0, 1, "pop_e",        ex(0, 0, 0,  0, 0, 1, 0));
        tbl[8] = mkv(0, 0, 4'd0,  0, 0, 0, 1, "ready_empty",  ex(0, 0, 0,  0, 0, 1, 0));

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].c, tbl[i].b, tbl[i].te, tbl[i].th, tbl[i].rr);
            check(tbl[i].name, tbl[i].e);
        end

        // Overflow: 18 pushes into a 16-deep FIFO with no reader.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) drive(0, 1, pcnt(i), pat(i), 0, 0, 0);
        check("fill_16", ex(1, pat(0), pcnt(0), 16, 0, 1, 0));
        for (int i = 16; i < 18; i++) drive(0, 1, pcnt(i), pat(i), 0, 0, 0);
        check("overflow_2", ex(1, pat(0), pcnt(0), 16, 2, 1, 0));

        // Full FIFO, push and pop together: both succeed, pointers wrap.
        drive(0, 1, 4'd7, pat(100), 0, 0, 1);
        check("full_push_pop", ex(1, pat(1), pcnt(1), 16, 2, 1, 0));
        for (int k = 1; k <= 16; k++) begin
            if (k <= 15) check($sformatf("drain_head_%0d", k), ex(1, pat(k), pcnt(k), 5'(17 - k), 2, 1, 0));
            else         check("drain_head_last", ex(1, pat(100), 4'd7, 1, 2, 1, 0));
            drive(0, 0, 0, 0, 0, 0, 1);
        end
        check("drained_empty", ex(0, 0, 0, 0, 2, 1, 0));

        // Reset in the middle of DRAIN with 7 entries queued.
        for (int i = 0; i < 7; i++) drive(0, 1, 4'd3, pat(200 + i), 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        check("drain_7", ex(1, pat(200), 4'd3, 7, 2, 2, 0));
        drive(1, 0, 0, 0, 0, 0, 0);
        check("reset_mid_drain", ex(0, 0, 0, 0, 0, 0, 0));

        // Drain sequence: 4 pushes, 5th push in the test_ending cycle.
        for (int i = 0; i < 4; i++) drive(0, 1, 4'd2, pat(20 + i), 0, 0, 0);
        drive(0, 1, 4'd2, pat(24), 1, 0, 0);
        check("ending_push", ex(1, pat(20), 4'd2, 5, 0, 2, 0));
        drive(0, 1, 4'd3, pat(60), 0, 0, 0);
        drive(0, 1, 4'd3, pat(61), 0, 0, 0);
        check("drain_ignores_push", ex(1, pat(20), 4'd2, 5, 0, 2, 0));
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 0, 0, 1, 1);
            check($sformatf("drain_pop_%0d", k), ex(1, pat(20 + k), 4'd2, 5'(5 - k), 0, 2, 0));
        end
        drive(0, 0, 0, 0, 0, 1, 1);
        check("done", ex(0, 0, 0, 0, 0, 3, 1));
        drive(0, 1, 4'd5, pat(70), 0, 0, 0);
        check("done_sticky", ex(0, 0, 0, 0, 0, 3, 1));

`ifdef DCT_TRACE_SLOT_TOTAL_EN
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4'd3,  pat(80), 0, 0, 0);
        drive(0, 1, 4'd12, pat(81), 0, 0, 0);
        drive(0, 1, 4'd0,  pat(82), 0, 0, 0);
        n_vec++;
        if (slot_total !== 32'd13) begin
            n_err++;
            $display("FAIL slot_total: got %0d want 13", slot_total);
        end
        check("slot_total_fill", ex(1, pat(80), 4'd3, 2, 0, 1, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
